// File: rtl/gru_fp_pkg.sv
`default_nettype none
// ============================================================================
// gru_fp_pkg : shared Q2.14 constants, FSM states and saturation helpers
// Rev 1.0
// ============================================================================
package gru_fp_pkg;

  localparam int DATABIT = 16;
  localparam int FRACBIT = 14;
  localparam int WIDEBIT = 2 * DATABIT;

  localparam logic [DATABIT-1:0] Q_ONE = 16'h4000;
  localparam logic [DATABIT-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATABIT-1:0] Q_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  function automatic logic ovf16(input logic signed [WIDEBIT-1:0] x);
    return (x > 32'sd32767) || (x < -32'sd32768);
  endfunction

  function automatic logic [DATABIT-1:0] sat16(input logic signed [WIDEBIT-1:0] x);
    if (x > 32'sd32767) begin
      return Q_MAX;
    end else if (x < -32'sd32768) begin
      return Q_MIN;
    end
    return x[DATABIT-1:0];
  endfunction

endpackage : gru_fp_pkg
`default_nettype wire

// File: rtl/grad_mult_q14.sv
`default_nettype none
// ============================================================================
// grad_mult_q14 : registered signed 16x16 multiply, >>FRACBIT, saturate to 16b
// Rev 1.0
// ============================================================================
module grad_mult_q14
  import gru_fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATABIT-1:0] i_a,
  input  logic [DATABIT-1:0] i_b,
  output logic [DATABIT-1:0] o_p,
  output logic               o_sat
);

  logic signed [WIDEBIT-1:0] w_prod;
  logic signed [WIDEBIT-1:0] w_shift;
  logic        [DATABIT-1:0] r_p;
  logic                      r_sat;

  assign w_prod  = $signed(i_a) * $signed(i_b);
  // Arithmetic shift floors toward -inf, which is the intended rounding.
  assign w_shift = w_prod >>> FRACBIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_sat <= 1'b0;
    end else begin
      r_p   <= sat16(w_shift);
      r_sat <= ovf16(w_shift);
    end
  end

  assign o_p   = r_p;
  assign o_sat = r_sat;

endmodule : grad_mult_q14
`default_nettype wire

// File: rtl/cal_ht_grad.sv
`default_nettype none
// ============================================================================
// cal_ht_grad : GRU hidden-state backward unit, d_ht1/d_htb/d_zt on one multiplier
// Rev 1.0
// ============================================================================
module cal_ht_grad
  import gru_fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATABIT-1:0] zt,
  input  logic [DATABIT-1:0] ht1,
  input  logic [DATABIT-1:0] htb,
  input  logic [DATABIT-1:0] dht,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATABIT-1:0] d_zt,
  output logic [DATABIT-1:0] d_ht1,
  output logic [DATABIT-1:0] d_htb,
  output logic               sat_flag
);

  state_t             r_state;
  logic [DATABIT-1:0] r_zt;
  logic [DATABIT-1:0] r_dht;
  logic [DATABIT-1:0] r_onesz;
  logic [DATABIT-1:0] r_diff;
  logic [DATABIT-1:0] r_cap_ht1;
  logic [DATABIT-1:0] r_cap_htb;
  logic               r_sat_acc;
  logic               r_out_valid;
  logic [DATABIT-1:0] r_d_zt;
  logic [DATABIT-1:0] r_d_ht1;
  logic [DATABIT-1:0] r_d_htb;
  logic               r_sat_flag;

  logic [DATABIT:0]          w_diff17;
  logic signed [WIDEBIT-1:0] w_diff_wide;
  logic [DATABIT-1:0]        w_mult_b;
  logic [DATABIT-1:0]        w_mult_p;
  logic                      w_mult_sat;
  logic                      w_accept;

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_diff17    = {ht1[DATABIT-1], ht1} - {htb[DATABIT-1], htb};
  assign w_diff_wide = $signed({{(WIDEBIT-DATABIT-1){w_diff17[DATABIT]}}, w_diff17});

  // Second multiplier operand follows the state; dht is always the first.
  always_comb begin
    w_mult_b = r_diff;
    case (r_state)
      ST_P0:   w_mult_b = r_zt;
      ST_P1:   w_mult_b = r_onesz;
      default: w_mult_b = r_diff;
    endcase
  end

  grad_mult_q14 u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_a   (r_dht),
    .i_b   (w_mult_b),
    .o_p   (w_mult_p),
    .o_sat (w_mult_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_zt        <= '0;
      r_dht       <= '0;
      r_onesz     <= '0;
      r_diff      <= '0;
      r_cap_ht1   <= '0;
      r_cap_htb   <= '0;
      r_sat_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_d_zt      <= '0;
      r_d_ht1     <= '0;
      r_d_htb     <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_zt      <= zt;
            r_dht     <= dht;
            // One-minus-gate wraps like the forward path does.
            r_onesz   <= Q_ONE - zt;
            r_diff    <= sat16(w_diff_wide);
            r_sat_acc <= ovf16(w_diff_wide);
            r_state   <= ST_P0;
          end
        end
        ST_P0: begin
          r_state <= ST_P1;
        end
        ST_P1: begin
          r_cap_ht1 <= w_mult_p;
          r_sat_acc <= r_sat_acc | w_mult_sat;
          r_state   <= ST_P2;
        end
        ST_P2: begin
          r_cap_htb <= w_mult_p;
          r_sat_acc <= r_sat_acc | w_mult_sat;
          r_state   <= ST_P3;
        end
        ST_P3: begin
          r_d_zt      <= w_mult_p;
          r_d_ht1     <= r_cap_ht1;
          r_d_htb     <= r_cap_htb;
          r_sat_flag  <= r_sat_acc | w_mult_sat;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign d_zt      = r_d_zt;
  assign d_ht1     = r_d_ht1;
  assign d_htb     = r_d_htb;
  assign sat_flag  = r_sat_flag;

endmodule : cal_ht_grad
`default_nettype wire

// File: tb/tb_cal_ht_grad.sv
`default_nettype none
// ============================================================================
// tb_cal_ht_grad : table, random and corner-sequence checks for cal_ht_grad
// Rev 1.0
// ============================================================================
module tb_cal_ht_grad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] zt = '0;
  logic [15:0] ht1 = '0;
  logic [15:0] htb = '0;
  logic [15:0] dht = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] d_zt;
  logic [15:0] d_ht1;
  logic [15:0] d_htb;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;

  logic [15:0] e_ht1, e_htb, e_zt;
  logic        e_sat;

  typedef struct {
    logic [15:0] zt, ht1, htb, dht;
    logic [15:0] e_ht1, e_htb, e_zt;
    logic        e_sat;
  } vec_t;

  vec_t vecs[4];

  cal_ht_grad dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .zt        (zt),
    .ht1       (ht1),
    .htb       (htb),
    .dht       (dht),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_zt      (d_zt),
    .d_ht1     (d_ht1),
    .d_htb     (d_htb),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, floor of product / 2^14, clamp to 16 bits.
  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  task automatic clamp(input longint v, output logic [15:0] r, output logic s);
    s = 1'b0;
    if (v > 32767) begin
      r = 16'h7FFF; s = 1'b1;
    end else if (v < -32768) begin
      r = 16'h8000; s = 1'b1;
    end else begin
      r = 16'(v);
    end
  endtask

  task automatic model(input logic [15:0] z, h1, hb, d,
                       output logic [15:0] oh1, ohb, oz, output logic os);
    logic [15:0] onesz, diff;
    logic        s0, s1, s2, s3;
    onesz = 16'(longint'(16384) - sx(z));
    clamp(sx(h1) - sx(hb), diff, s0);
    clamp((sx(d) * sx(z)) >>> 14, oh1, s1);
    clamp((sx(d) * sx(onesz)) >>> 14, ohb, s2);
    clamp((sx(d) * sx(diff)) >>> 14, oz, s3);
    os = s0 | s1 | s2 | s3;
  endtask

  // Drives one transaction and waits for out_valid; leaves the DUT holding OUT.
  task automatic start_and_wait(input logic [15:0] z, h1, hb, d);
    int lat;
    model(z, h1, hb, d, e_ht1, e_htb, e_zt, e_sat);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    zt = z; ht1 = h1; htb = hb; dht = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // Accept cycle is cycle 0; results show in cycle 5, four edges past the accept edge.
    chk("latency_edges", 32'(lat), 32'd4);
    chk("d_ht1", 32'(d_ht1), 32'(e_ht1));
    chk("d_htb", 32'(d_htb), 32'(e_htb));
    chk("d_zt", 32'(d_zt), 32'(e_zt));
    chk("sat_flag", 32'(sat_flag), 32'(e_sat));
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'h4000, 16'h4000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h4000, 1'b0};
    vecs[1] = '{16'h2000, 16'h4000, 16'h0000, 16'h4000, 16'h2000, 16'h2000, 16'h4000, 1'b0};
    vecs[2] = '{16'h2000, 16'h0000, 16'h4000, 16'hC000, 16'hE000, 16'hE000, 16'h4000, 1'b0};
    vecs[3] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d_zt", 32'(d_zt), 32'd0);
    chk("rst_d_ht1", 32'(d_ht1), 32'd0);
    chk("rst_d_htb", 32'(d_htb), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      start_and_wait(vecs[i].zt, vecs[i].ht1, vecs[i].htb, vecs[i].dht);
      chk("tbl_d_ht1", 32'(d_ht1), 32'(vecs[i].e_ht1));
      chk("tbl_d_htb", 32'(d_htb), 32'(vecs[i].e_htb));
      chk("tbl_d_zt", 32'(d_zt), 32'(vecs[i].e_zt));
      chk("tbl_sat", 32'(sat_flag), 32'(vecs[i].e_sat));
      finish_txn();
    end

    // A clean transaction right after the saturating one must clear sat_flag.
    start_and_wait(16'h1000, 16'h0800, 16'h0400, 16'h2000);
    chk("sat_cleared", 32'(sat_flag), 32'd0);
    finish_txn();

    for (int i = 0; i < 40; i++) begin
      start_and_wait(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      finish_txn();
    end

    // Backpressure with ignored in_valid pulses during the stall.
    out_ready = 1'b0;
    start_and_wait(16'h2000, 16'h4000, 16'h0000, 16'h4000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      zt = 16'($urandom); ht1 = 16'($urandom); htb = 16'($urandom); dht = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_d_ht1", 32'(d_ht1), 32'(e_ht1));
      chk("bp_d_htb", 32'(d_htb), 32'(e_htb));
      chk("bp_d_zt", 32'(d_zt), 32'(e_zt));
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_txn();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_ghost_txn", 32'(out_valid), 32'd0);
    chk("retain_d_ht1", 32'(d_ht1), 32'h2000);
    chk("retain_d_zt", 32'(d_zt), 32'h4000);

    // Reset while the unit is in P2.
    @(negedge clk);
    zt = 16'h0000; ht1 = 16'h7FFF; htb = 16'h8000; dht = 16'h7FFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_d_zt", 32'(d_zt), 32'd0);
    chk("midrst_d_ht1", 32'(d_ht1), 32'd0);
    chk("midrst_d_htb", 32'(d_htb), 32'd0);
    chk("midrst_sat", 32'(sat_flag), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    start_and_wait(16'h2000, 16'h4000, 16'h0000, 16'h4000);
    chk("post_rst_sat", 32'(sat_flag), 32'd0);
    finish_txn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cal_ht_grad
`default_nettype wire
